// File: rtl/ask_tx_pkg.sv
// Shared types and constants for the ASK transmitter framing logic.
// The optional sync word is enabled with the ASK_SYNC_WORD_EN macro
// (see prbs_frame_ctrl).
package ask_tx_pkg;

  localparam int LFSR_W = 13;
  localparam int SYNC_W = 13;

  // Feedback taps of the 13-bit PRBS polynomial.
  localparam int TAP_A = 12;
  localparam int TAP_B = 11;
  localparam int TAP_C = 10;
  localparam int TAP_D = 7;

  // Frame sequencer states. SYNC is only reachable with ASK_SYNC_WORD_EN.
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SYNC,
    PAYLOAD,
    GAP
  } state_t;

  // Feedback bit of the LFSR; also the payload bit for the current state.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/prbs13_core.sv
// 13-bit PRBS register. Steps only when told to, loads a new seed on
// request, and never stays stuck at zero: an all-zero value (or an
// all-zero load request) is replaced by SEED.
module prbs13_core
  import ask_tx_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 13'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic              fb
);

  logic [LFSR_W-1:0] s;

  // LFSR register: load has priority over zero lock-out, which has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= SEED;
    end else if (load) begin
      s <= (load_val == '0) ? SEED : load_val;
    end else if (s == '0) begin
      s <= SEED;
    end else if (step) begin
      s <= {s[LFSR_W-2:0], fb};
    end
  end

  // Feedback bit is exposed as the payload bit for the current register value.
  always_comb begin
    fb = lfsr_fb(s);
  end

endmodule

// File: rtl/prbs_frame_ctrl.sv
// Frame sequencer for the ASK transmitter: preamble, optional sync word,
// PRBS payload and a carrier-off gap, each bit held CLKS_PER_BIT clocks.
// Optional feature macro: ASK_SYNC_WORD_EN (adds a 13-bit SYNC_WORD field
// between preamble and payload).
//
// Handshake: start is a request level sampled only while busy=0; busy acts
// as the inverse of ready, so a start seen while busy=1 is dropped, not
// queued. seed_load follows the same rule.
module prbs_frame_ctrl
  import ask_tx_pkg::*;
#(
  parameter int unsigned       CLKS_PER_BIT = 16,
  parameter int unsigned       PREAMBLE_LEN = 8,
  parameter int unsigned       PAYLOAD_LEN  = 64,
  parameter int unsigned       GAP_LEN      = 4,
  parameter logic [LFSR_W-1:0] SEED         = 13'd1,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = 13'h1CF5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              busy,
  output logic              tx_en,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              done,
  output logic [7:0]        frame_cnt,
  output state_t            state_dbg
);

  // Bit timer width; bit index is 16 bits, enough for any field length below 65536.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = 16;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   bit_idx;
  logic            period_end;
  logic            bit_last;
  logic            lfsr_step;
  logic            lfsr_load;
  logic            lfsr_bit;

`ifdef ASK_SYNC_WORD_EN
  logic [3:0]      sync_sel;
`else
  logic            unused_sync;
  assign unused_sync = ^SYNC_WORD;
`endif

  // LFSR advances once per payload bit, on the last clock of the period.
  assign lfsr_step = (state == PAYLOAD) && period_end;
  assign lfsr_load = (state == IDLE) && seed_load;

  prbs13_core #(
    .SEED (SEED)
  ) u_prbs (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (seed_in),
    .fb       (lfsr_bit)
  );

  // Period and field boundary detection.
  always_comb begin
    period_end = (timer == TW'(CLKS_PER_BIT - 1));
    bit_last   = 1'b0;
    case (state)
      PREAMBLE: bit_last = (bit_idx == IW'(PREAMBLE_LEN - 1));
      SYNC:     bit_last = (bit_idx == IW'(SYNC_W - 1));
      PAYLOAD:  bit_last = (bit_idx == IW'(PAYLOAD_LEN - 1));
      GAP:      bit_last = (bit_idx == IW'(GAP_LEN - 1));
      default:  bit_last = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fields advance when their last bit period ends.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
`ifdef ASK_SYNC_WORD_EN
        if (period_end && bit_last) state_nxt = SYNC;
`else
        if (period_end && bit_last) state_nxt = PAYLOAD;
`endif
      end
      SYNC: begin
        if (period_end && bit_last) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (period_end && bit_last) state_nxt = GAP;
      end
      GAP: begin
        if (period_end && bit_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer and per-field bit index; both held at zero while idle.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      timer <= period_end ? '0 : timer + 1'b1;
      if (period_end) begin
        bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
      end
    end
  end

  // Completed-frame counter, bumped on the done pulse and wrapping at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (done) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

`ifdef ASK_SYNC_WORD_EN
  // Sync word is sent MSB first.
  assign sync_sel = 4'(SYNC_W - 1) - bit_idx[3:0];
`endif

  // Output decode from state, timer and bit index.
  always_comb begin
    busy      = 1'b0;
    tx_en     = 1'b0;
    bit_out   = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
    case (state)
      PREAMBLE: begin
        busy      = 1'b1;
        tx_en     = 1'b1;
        bit_out   = ~bit_idx[0];
        bit_valid = (timer == '0);
      end
`ifdef ASK_SYNC_WORD_EN
      SYNC: begin
        busy      = 1'b1;
        tx_en     = 1'b1;
        bit_out   = SYNC_WORD[sync_sel];
        bit_valid = (timer == '0);
      end
`endif
      PAYLOAD: begin
        busy      = 1'b1;
        tx_en     = 1'b1;
        bit_out   = lfsr_bit;
        bit_valid = (timer == '0);
      end
      GAP: begin
        busy      = 1'b1;
        bit_valid = (timer == '0);
        done      = period_end && bit_last;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Bench for prbs_frame_ctrl with CLKS_PER_BIT=4, PREAMBLE_LEN=8,
// PAYLOAD_LEN=64, GAP_LEN=4, SEED=1. Honours ASK_SYNC_WORD_EN.
module tb_prbs_frame_ctrl;
  import ask_tx_pkg::*;

  localparam int CPB     = 4;
  localparam int PRE_LEN = 8;
  localparam int PAY_LEN = 64;
  localparam int GAP_N   = 4;
`ifdef ASK_SYNC_WORD_EN
  localparam int SYNC_BITS = 13;
`else
  localparam int SYNC_BITS = 0;
`endif
  localparam int FRAME_CLKS = (PRE_LEN + SYNC_BITS + PAY_LEN + GAP_N) * CPB;
  localparam int PL_BIT     = PRE_LEN + SYNC_BITS;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        seed_load;
  logic [12:0] seed_in;
  logic        busy, tx_en, bit_out, bit_valid, done;
  logic [7:0]  frame_cnt;
  state_t      state_dbg;

  always #5 clk = ~clk;

  prbs_frame_ctrl #(
    .CLKS_PER_BIT (CPB),
    .PREAMBLE_LEN (PRE_LEN),
    .PAYLOAD_LEN  (PAY_LEN),
    .GAP_LEN      (GAP_N),
    .SEED         (13'd1),
    .SYNC_WORD    (13'h1CF5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy),
    .tx_en     (tx_en),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .done      (done),
    .frame_cnt (frame_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [0:0]  exp_q[$];
  logic [12:0] model_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference PRBS: taps 12,11,10,7 as a mask parity.
  task automatic fill_exp(input int n);
    logic fb;
    for (int i = 0; i < n; i++) begin
      fb = ^(model_s & 13'h1C80);
      exp_q.push_back(fb);
      model_s = (model_s == 13'd0) ? 13'd1 : {model_s[11:0], fb};
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a frame (optionally with a simultaneous seed load) and check it fully.
  task automatic run_frame(input logic do_load, input logic [12:0] sv,
                           input logic [7:0] exp_fc, input string tag,
                           output logic first_bit);
    int   n;
    int   busy_cnt;
    int   done_cnt;
    int   done_cyc;
    logic exp_b;
    logic [12:0] sync_w;
    sync_w    = 13'h1CF5;
    n         = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_cyc  = -1;
    first_bit = 1'bx;
    if (do_load) model_s = (sv == 13'd0) ? 13'd1 : sv;
    exp_q.delete();
    fill_exp(PAY_LEN);
    start = 1'b1; seed_load = do_load; seed_in = sv;
    step();
    start = 1'b0; seed_load = 1'b0; seed_in = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!busy) break;
      busy_cnt++;
      if (bit_valid) begin
        if (n >= PL_BIT && n < PL_BIT + PAY_LEN) begin
          exp_b = exp_q.pop_front();
          if (n == PL_BIT) first_bit = bit_out;
          check($sformatf("%s_pay%0d", tag, n - PL_BIT), 32'(bit_out), 32'(exp_b));
        end
`ifdef ASK_SYNC_WORD_EN
        if (n >= PRE_LEN && n < PL_BIT)
          check($sformatf("%s_sync%0d", tag, n - PRE_LEN), 32'(bit_out),
                32'(sync_w[12 - (n - PRE_LEN)]));
`endif
        n++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      step();
    end
    check($sformatf("%s_ended", tag), 32'(busy), 32'd0);
    check($sformatf("%s_busy_len", tag), busy_cnt, FRAME_CLKS);
    check($sformatf("%s_done_cnt", tag), done_cnt, 1);
    check($sformatf("%s_done_cyc", tag), done_cyc, FRAME_CLKS - 1);
    check($sformatf("%s_strobes", tag), n, PL_BIT + PAY_LEN + GAP_N);
    check($sformatf("%s_frame_cnt", tag), 32'(frame_cnt), 32'(exp_fc));
    check($sformatf("%s_q_empty", tag), exp_q.size(), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          cyc;
    logic        start;
    logic        seed_load;
    logic [12:0] seed_in;
    logic [4:0]  exp;   // {busy, tx_en, bit_out, bit_valid, done}
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input int c, input logic st, input logic sl,
                              input logic [12:0] si, input logic [4:0] e);
    vec_t v;
    v.cyc = c; v.start = st; v.seed_load = sl; v.seed_in = si; v.exp = e;
    return v;
  endfunction

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   pl;
    int   g;
    int   idle_busy;
    int   done_seen;
    logic fb0;

    pl = PL_BIT * CPB;
    g  = pl + PAY_LEN * CPB;
    vecs[0]  = mk(0,      0, 0, 13'h0,    5'b11110);
    vecs[1]  = mk(1,      0, 0, 13'h0,    5'b11100);
    vecs[2]  = mk(4,      0, 0, 13'h0,    5'b11010);
    vecs[3]  = mk(7,      0, 0, 13'h0,    5'b11000);
    vecs[4]  = mk(8,      0, 0, 13'h0,    5'b11110);
    vecs[5]  = mk(28,     0, 0, 13'h0,    5'b11010);
    vecs[6]  = mk(pl,     0, 0, 13'h0,    5'b11010);
    vecs[7]  = mk(pl + 3, 1, 1, 13'h1000, 5'b11000);
    vecs[8]  = mk(pl + 4, 0, 0, 13'h0,    5'b11010);
    vecs[9]  = mk(pl + 28, 0, 0, 13'h0,   5'b11110);
    vecs[10] = mk(pl + 31, 0, 0, 13'h0,   5'b11100);
    vecs[11] = mk(pl + 32, 0, 0, 13'h0,   5'b11010);
    vecs[12] = mk(pl + 33, 1, 0, 13'h0,   5'b11000);
    vecs[13] = mk(g,      0, 0, 13'h0,    5'b10010);
    vecs[14] = mk(g + 1,  0, 1, 13'h0ABC, 5'b10000);
    vecs[15] = mk(g + 12, 0, 0, 13'h0,    5'b10010);
    vecs[16] = mk(g + 15, 0, 0, 13'h0,    5'b10001);
    vecs[17] = mk(g + 16, 0, 0, 13'h0,    5'b00000);

    // Reset.
    rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    model_s = 13'd1;
    check("rst_outputs", 32'({busy, tx_en, bit_out, bit_valid, done}), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Table-driven first frame, with start/seed_load pokes while busy.
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 18; i++) begin
      while (cyc < vecs[i].cyc) begin
        step();
        cyc++;
      end
      check($sformatf("vec%0d_c%0d", i, cyc),
            32'({busy, tx_en, bit_out, bit_valid, done}), 32'(vecs[i].exp));
      start = vecs[i].start; seed_load = vecs[i].seed_load; seed_in = vecs[i].seed_in;
      step();
      cyc++;
      start = 1'b0; seed_load = 1'b0; seed_in = '0;
    end
    check("tbl_frame_cnt", 32'(frame_cnt), 32'd1);
    fill_exp(PAY_LEN);
    exp_q.delete();

    // No queued frame from the starts issued while busy.
    idle_busy = 0;
    repeat (20) begin
      step();
      if (busy) idle_busy++;
    end
    check("no_queued_frame", idle_busy, 0);

    // Second frame continues the PRBS sequence (seed untouched by busy-time loads).
    run_frame(1'b0, 13'h0, 8'd2, "cont", fb0);

    // Zero seed load in IDLE falls back to SEED.
    seed_load = 1'b1; seed_in = 13'h0;
    step();
    seed_load = 1'b0;
    model_s = 13'd1;
    run_frame(1'b0, 13'h0, 8'd3, "seed0", fb0);
    check("seed0_first_bit", 32'(fb0), 32'd0);

    // Seed load together with start: frame uses the new seed.
    run_frame(1'b1, 13'h1000, 8'd4, "seed1000", fb0);
    check("seed1000_first_bit", 32'(fb0), 32'd1);

    // Reset during payload bit 20.
    done_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < (PL_BIT + 20) * CPB + 1; c++) begin
      if (done) done_seen++;
      step();
    end
    check("pre_rst_txen", 32'({busy, tx_en, bit_valid}), 32'b110);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_outputs", 32'({busy, tx_en, bit_out, bit_valid, done}), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_no_done", done_seen, 0);
    model_s = 13'd1;
    run_frame(1'b0, 13'h0, 8'd1, "after_rst", fb0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
